// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the countdown timer bank.
// Auto-reload support is compiled in with TIMER_BANK_AUTORELOAD_EN.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

  // All-ones count for a given width, the value every channel shows out of reset.
  function automatic int unsigned default_load(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/countdown_timer_channel.sv
// One countdown channel: load on start, decrement per tick, flag expiry.
// Reload/mode registers exist only when TIMER_BANK_AUTORELOAD_EN is defined.
module countdown_timer_channel
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH        = 7,
  parameter int unsigned DEFAULT_LOAD = 127
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             auto_reload_i,
  input  logic             pause_i,
  output logic [WIDTH-1:0] count_o,
  output logic             timer_up_o,
  output logic             expired_o
);

  localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(DEFAULT_LOAD);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  timer_state_e     state_q;
  logic [WIDTH-1:0] count_q;
  logic             timer_up_q;
  logic             expired_q;

`ifdef TIMER_BANK_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic             mode_q;
`else
  logic unused_auto_reload;
  assign unused_auto_reload = auto_reload_i;
`endif

  // Start beats pause, pause beats tick; zero is reached only via expiry, so no wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= RESET_COUNT;
      timer_up_q <= 1'b0;
      expired_q  <= 1'b0;
`ifdef TIMER_BANK_AUTORELOAD_EN
      reload_q   <= '0;
      mode_q     <= 1'b0;
`endif
    end else begin
      expired_q <= 1'b0;
      if (start_i) begin
        count_q <= load_value_i;
`ifdef TIMER_BANK_AUTORELOAD_EN
        reload_q <= load_value_i;
        mode_q   <= auto_reload_i;
`endif
        if (load_value_i != '0) begin
          state_q    <= RUN;
          timer_up_q <= 1'b0;
        end else begin
          state_q    <= DONE;
          timer_up_q <= 1'b1;
          expired_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (tick_i && !pause_i) begin
              if (count_q > ONE) begin
                count_q <= count_q - ONE;
              end else begin
                expired_q <= 1'b1;
`ifdef TIMER_BANK_AUTORELOAD_EN
                if (mode_q && (reload_q != '0)) begin
                  count_q <= reload_q;
                end else begin
                  count_q    <= '0;
                  state_q    <= DONE;
                  timer_up_q <= 1'b1;
                end
`else
                count_q    <= '0;
                state_q    <= DONE;
                timer_up_q <= 1'b1;
`endif
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign count_o    = count_q;
  assign timer_up_o = timer_up_q;
  assign expired_o  = expired_q;

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of independent countdown timers sharing one timebase tick.
// Define TIMER_BANK_AUTORELOAD_EN to enable per-channel periodic reload.
module countdown_timer_bank
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH        = 7,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned DEFAULT_LOAD = default_load(WIDTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick_i,
  input  logic [CHANNELS-1:0]       start_i,
  input  logic [CHANNELS*WIDTH-1:0] load_value_i,
  input  logic [CHANNELS-1:0]       auto_reload_i,
  input  logic [CHANNELS-1:0]       pause_i,
  output logic [CHANNELS*WIDTH-1:0] count_o,
  output logic [CHANNELS-1:0]       timer_up_o,
  output logic [CHANNELS-1:0]       expired_o
);

  // Each channel owns one WIDTH-bit slice of the packed count/load vectors.
  for (genvar g = 0; g < CHANNELS; g++) begin : gen_channel
    countdown_timer_channel #(
      .WIDTH        (WIDTH),
      .DEFAULT_LOAD (DEFAULT_LOAD)
    ) u_channel (
      .clk           (clk),
      .reset         (reset),
      .tick_i        (tick_i),
      .start_i       (start_i[g]),
      .load_value_i  (load_value_i[g*WIDTH +: WIDTH]),
      .auto_reload_i (auto_reload_i[g]),
      .pause_i       (pause_i[g]),
      .count_o       (count_o[g*WIDTH +: WIDTH]),
      .timer_up_o    (timer_up_o[g]),
      .expired_o     (expired_o[g])
    );
  end

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Directed self-checking bench for countdown_timer_bank (WIDTH=7, CHANNELS=2).
// Channel 1 expectations follow TIMER_BANK_AUTORELOAD_EN.
module tb_countdown_timer_bank;

  logic        clk;
  logic        reset;
  logic        tick;
  logic [1:0]  start;
  logic [13:0] loadValue;
  logic [1:0]  autoReload;
  logic [1:0]  pause;
  logic [13:0] count;
  logic [1:0]  timerUp;
  logic [1:0]  expired;

  int checks;
  int failures;

`ifdef TIMER_BANK_AUTORELOAD_EN
  int ch1Count [6] = '{1, 2, 1, 2, 1, 2};
  int ch1Exp   [6] = '{0, 1, 0, 1, 0, 1};
  int ch1Up    [6] = '{0, 0, 0, 0, 0, 0};
`else
  int ch1Count [6] = '{1, 0, 0, 0, 0, 0};
  int ch1Exp   [6] = '{0, 1, 0, 0, 0, 0};
  int ch1Up    [6] = '{0, 1, 1, 1, 1, 1};
`endif

  countdown_timer_bank dut (
    .clk           (clk),
    .reset         (reset),
    .tick_i        (tick),
    .start_i       (start),
    .load_value_i  (loadValue),
    .auto_reload_i (autoReload),
    .pause_i       (pause),
    .count_o       (count),
    .timer_up_o    (timerUp),
    .expired_o     (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle with the given inputs; start and tick are single-cycle strobes.
  task automatic applyStimulus(input logic t, input logic [1:0] s, input logic [13:0] lv,
                               input logic [1:0] ar, input logic [1:0] p);
    tick       = t;
    start      = s;
    loadValue  = lv;
    autoReload = ar;
    pause      = p;
    @(posedge clk);
    #1;
    tick  = 1'b0;
    start = 2'b00;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    tick       = 1'b0;
    start      = 2'b00;
    loadValue  = '0;
    autoReload = 2'b00;
    pause      = 2'b00;

    idleCycle();
    idleCycle();
    checkOutput("reset_count", int'(count), 16383);
    checkOutput("reset_timer_up", int'(timerUp), 0);
    checkOutput("reset_expired", int'(expired), 0);
    reset = 1'b0;

    $display("[TB] ticks without start");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'b00, 14'd0, 2'b00, 2'b00);
      checkOutput("idle_count", int'(count), 16383);
      checkOutput("idle_flags", int'({timerUp, expired}), 0);
    end

    $display("[TB] channel 0 one-shot load 3");
    applyStimulus(1'b0, 2'b01, {7'd0, 7'd3}, 2'b00, 2'b00);
    checkOutput("ch0_load3", int'(count[6:0]), 3);
    checkOutput("ch0_load3_up", int'(timerUp[0]), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b00, 14'd0, 2'b00, 2'b00);
      checkOutput("ch0_tick_count", int'(count[6:0]), 2 - i);
      checkOutput("ch0_tick_expired", int'(expired[0]), (i == 2) ? 1 : 0);
      checkOutput("ch0_tick_up", int'(timerUp[0]), (i == 2) ? 1 : 0);
      for (int j = 0; j < 3; j++) idleCycle();
    end
    checkOutput("ch0_expired_cleared", int'(expired[0]), 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 2'b00, 14'd0, 2'b00, 2'b00);
      checkOutput("ch0_done_count", int'(count[6:0]), 0);
      checkOutput("ch0_done_up", int'(timerUp[0]), 1);
      checkOutput("ch0_done_expired", int'(expired[0]), 0);
    end

    $display("[TB] channel 1 load 2 with auto_reload");
    applyStimulus(1'b0, 2'b10, {7'd2, 7'd0}, 2'b10, 2'b00);
    checkOutput("ch1_load2", int'(count[13:7]), 2);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2'b00, 14'd0, 2'b00, 2'b00);
      checkOutput("ch1_count", int'(count[13:7]), ch1Count[i]);
      checkOutput("ch1_expired", int'(expired[1]), ch1Exp[i]);
      checkOutput("ch1_up", int'(timerUp[1]), ch1Up[i]);
    end

    $display("[TB] channel 0 pause");
    applyStimulus(1'b0, 2'b01, {7'd0, 7'd5}, 2'b00, 2'b00);
    checkOutput("ch0_load5", int'(count[6:0]), 5);
    checkOutput("ch0_load5_up", int'(timerUp[0]), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b00, 14'd0, 2'b00, 2'b01);
      checkOutput("ch0_paused", int'(count[6:0]), 5);
    end
    applyStimulus(1'b1, 2'b00, 14'd0, 2'b00, 2'b00);
    checkOutput("ch0_unpaused", int'(count[6:0]), 4);

    $display("[TB] start versus tick in DONE");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b00, 14'd0, 2'b00, 2'b00);
    checkOutput("ch0_back_to_done", int'({timerUp[0], count[6:0]}), 128);
    applyStimulus(1'b1, 2'b01, {7'd0, 7'd9}, 2'b00, 2'b00);
    checkOutput("ch0_start_beats_tick", int'(count[6:0]), 9);
    checkOutput("ch0_up_falls", int'(timerUp[0]), 0);
    checkOutput("ch0_no_expire", int'(expired[0]), 0);
    applyStimulus(1'b0, 2'b01, {7'd0, 7'd0}, 2'b00, 2'b00);
    checkOutput("ch0_zero_count", int'(count[6:0]), 0);
    checkOutput("ch0_zero_up", int'(timerUp[0]), 1);
    checkOutput("ch0_zero_expired", int'(expired[0]), 1);
    idleCycle();
    checkOutput("ch0_zero_pulse_end", int'(expired[0]), 0);
    checkOutput("ch0_zero_up_held", int'(timerUp[0]), 1);

    $display("[TB] asynchronous reset mid-count");
    applyStimulus(1'b0, 2'b01, {7'd0, 7'd42}, 2'b00, 2'b00);
    applyStimulus(1'b1, 2'b00, 14'd0, 2'b00, 2'b00);
    applyStimulus(1'b1, 2'b00, 14'd0, 2'b00, 2'b00);
    checkOutput("ch0_at_40", int'(count[6:0]), 40);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_count", int'(count), 16383);
    checkOutput("async_reset_flags", int'({timerUp, expired}), 0);
    idleCycle();
    reset = 1'b0;
    applyStimulus(1'b1, 2'b00, 14'd0, 2'b00, 2'b00);
    checkOutput("post_reset_idle", int'(count), 16383);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
